pipelined_rca_adder: RTL and testbench
======================================

// Module: pipelined_rca_adder
// PURPOSE
//  Parametrised, pipelined ripple-carry adder/subtractor. It is the successor to the team's fixed
//  4-bit RCA: WIDTH-bit operands are split into SEG_W-bit segments, and one segment resolves per
//  pipeline stage, with the carry registered between stages. It sits between operand sources and
//  the ALU result path, using a valid/ready handshake, at one operation per cycle.
// PARAMETERS
//  WIDTH  16  operand/result width; must be a multiple of SEG_W (elaboration error otherwise)
//  SEG_W  4   segment width; STAGES = WIDTH/SEG_W pipeline stages (STAGES >= 1)
// PORTS
//  CLK        in   1      single clock; all state updates on rising edge
//  RST        in   1      synchronous, active-high reset
//  IN_VALID   in   1      A/B/C_IN/SUB are valid this cycle
//  IN_READY   out  1      block accepts an operation this cycle
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  C_IN       in   1      carry-in (add) / borrow-in (sub)
//  SUB        in   1      0: A+B+C_IN; 1: A-B-C_IN
//  OUT_VALID  out  1      SUM/C_OUT valid
//  OUT_READY  in   1      consumer takes the result this cycle
//  SUM        out  WIDTH  result, modulo 2^WIDTH
//  C_OUT      out  1      carry-out; in SUB mode 1 = no borrow
//  OVF        out  1      signed overflow (present only with PRCA_OVF_EN)
// BEHAVIOUR
//  - Reset: every stage valid bit=0; OUT_VALID=0, SUM=0, C_OUT=0, OVF=0. The synchronous reset
//    flushes in-flight operations mid-stream with no partial output.
//  - Advance: adv = !OUT_VALID | OUT_READY. IN_READY = adv (combinational).
//    - When adv=0, all stage registers hold, including the data of invalid stages.
//  - Accept: an operation is accepted when IN_VALID & IN_READY. Bubbles (adv=1, IN_VALID=0)
//    propagate as valid=0.
//  - Latency: exactly STAGES cycles from accept to OUT_VALID, with zero stalls.
//    Throughput: 1 op/cycle while OUT_READY=1.
//  - Arithmetic: Beff = SUB ? ~B : B; cin0 = SUB ? ~C_IN : C_IN.
//    - Stage k adds segment k of A and Beff plus the carry registered from stage k-1
//      (cin0 for k=0).
//    - Upper operand segments are skewed (delayed) to meet their carry; lower result segments
//      are deskewed so that SUM leaves aligned.
//  - SUB: computes A + ~B + ~C_IN = A - B - C_IN mod 2^WIDTH. C_OUT=0 exactly when a borrow
//    occurred.
//  - C_OUT is the carry out of the MSB segment in the final stage.
//  - SUB and C_IN travel with their operation; mixed add/sub streams are legal back-to-back.
//  - Output register holds SUM/C_OUT stable while OUT_VALID & !OUT_READY.
//  - Simultaneous pop and push at full occupancy is allowed (adv=1), with no bubble inserted.
//  - STAGES=1 degenerates to a registered single-cycle adder with the same handshake.
// CONFIGURATION
//  - Macro PRCA_OVF_EN. When defined, port OVF exists: OVF = carry into MSB XOR carry out of MSB,
//    registered alongside SUM (two's-complement overflow of the add or sub). Reset value 0.
//  - Without PRCA_OVF_EN, OVF is not a port and no extra flops exist; all other behaviour is
//    identical.
// STRUCTURE
//  - Package prca_pkg holds the default WIDTH/SEG_W constants and the function
//    stages(WIDTH,SEG_W).
//  - Sub-module rca_segment (combinational SEG_W-bit ripple adder: a, b, cin -> s, cout, c_msb_in)
//    is instantiated once per stage via generate.
//  - Skew/deskew registers and valid bits stay in the top module.
// TESTING (WIDTH=16, SEG_W=4, OUT_READY=1 unless stated)
//  1. A=16'hFFFF, B=16'h0001, C_IN=0, SUB=0 -> 4 cycles later SUM=16'h0000, C_OUT=1,
//     OVF=0 (if enabled).
//  2. A=16'h1234, B=16'h0235, C_IN=0, SUB=1 -> SUM=16'h0FFF, C_OUT=1.
//     A=16'h0001, B=16'h0002, SUB=1 -> SUM=16'hFFFF, C_OUT=0.
//  3. Stream 8 back-to-back ops (A=i, B=16'h00FF, alternating SUB) -> 8 consecutive OUT_VALID
//     cycles, in order, each matching the reference model.
//  4. Backpressure: OUT_READY=0 for 5 cycles mid-stream. IN_READY must drop once OUT_VALID=1,
//     SUM must hold, and no result may be lost or duplicated after OUT_READY=1.
//  5. OVF (with PRCA_OVF_EN): 16'h7FFF+16'h0001 -> SUM=16'h8000, OVF=1;
//     16'h8000-16'h0001 (SUB) -> SUM=16'h7FFF, OVF=1.
//  6. Assert RST for 1 cycle with 3 ops in flight -> OUT_VALID=0, SUM=0 next cycle,
//     and no stale result ever appears.

Source files
------------

// File: rtl/prca_pkg.sv
// Shared sizing for the pipelined ripple-carry adder/subtractor.
// Default operand width, segment width and the stage-count helper.
package prca_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEG_W = 4;

    function automatic int stages(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational SEG_W-bit ripple-carry segment; zero latency, no handshake.
// c_msb_in is the carry entering the top bit, used for signed overflow detection.
module rca_segment
    import prca_pkg::*;
#(
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [SEG_W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < SEG_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c[SEG_W];
    assign c_msb_in = c[SEG_W-1];

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined add/sub, one SEG_W segment per stage; latency STAGES cycles, 1 op/cycle.
// Whole pipe stalls while OUT_VALID & !OUT_READY (IN_READY low); OVF port only with PRCA_OVF_EN.
module pipelined_rca_adder
    import prca_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_IN,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             C_OUT
`ifdef PRCA_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int STAGES = stages(WIDTH, SEG_W);

    if (SEG_W < 1 || WIDTH < SEG_W || (WIDTH % SEG_W) != 0) begin : g_bad_cfg
        $error("pipelined_rca_adder: WIDTH must be a non-zero multiple of SEG_W");
    end

    logic             adv;
    logic [WIDTH-1:0] beff;
    logic             cin0;

    assign adv      = !OUT_VALID || OUT_READY;
    assign IN_READY = adv;
    assign beff     = B ^ {WIDTH{SUB}};
    assign cin0     = C_IN ^ SUB;

    // aw_q starts as operand A and rotates right one segment per stage, with the fresh
    // sum segment entering at the top; after STAGES rotations it is the aligned SUM.
    // B shrinks instead, keeping only the segments still to be consumed.
    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int BW = WIDTH - k * SEG_W;

        logic             vld_in;
        logic [WIDTH-1:0] a_in;
        logic [BW-1:0]    b_in;
        logic             c_in;
        logic [SEG_W-1:0] s;
        logic             co;
        logic             c_msb;
        logic [WIDTH-1:0] aw_d;
        logic             vld_q;
        logic             cy_q;
        logic [WIDTH-1:0] aw_q;

        if (k == 0) begin : g_src
            assign vld_in = IN_VALID;
            assign a_in   = A;
            assign b_in   = beff;
            assign c_in   = cin0;
        end else begin : g_src
            assign vld_in = stg[k-1].vld_q;
            assign a_in   = stg[k-1].aw_q;
            assign b_in   = stg[k-1].g_b.bw_q;
            assign c_in   = stg[k-1].cy_q;
        end

        rca_segment #(.SEG_W(SEG_W)) u_seg (
            .a        (a_in[SEG_W-1:0]),
            .b        (b_in[SEG_W-1:0]),
            .cin      (c_in),
            .s        (s),
            .cout     (co),
            .c_msb_in (c_msb)
        );

        assign aw_d = (a_in >> SEG_W) | (WIDTH'(s) << (WIDTH - SEG_W));

        always_ff @(posedge CLK) begin
            if (RST) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                aw_q  <= '0;
            end else if (adv) begin
                vld_q <= vld_in;
                cy_q  <= co;
                aw_q  <= aw_d;
            end
        end

        if (k < STAGES - 1) begin : g_b
            logic [BW-SEG_W-1:0] bw_q;
            logic [BW-SEG_W-1:0] bw_d;

            assign bw_d = b_in[BW-1:SEG_W];

            always_ff @(posedge CLK) begin
                if (RST) begin
                    bw_q <= '0;
                end else if (adv) begin
                    bw_q <= bw_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
`ifdef PRCA_OVF_EN
            logic ovf_q;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= c_msb ^ co;
                end
            end
`else
            logic unused_c_msb;
            assign unused_c_msb = c_msb;
`endif
        end else begin : g_mid
            logic unused_c_msb;
            assign unused_c_msb = c_msb;
        end
    end

    assign OUT_VALID = stg[STAGES-1].vld_q;
    assign SUM       = stg[STAGES-1].aw_q;
    assign C_OUT     = stg[STAGES-1].cy_q;
`ifdef PRCA_OVF_EN
    assign OVF       = stg[STAGES-1].g_last.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Scoreboard bench for pipelined_rca_adder at WIDTH=16, SEG_W=4.
module tb_pipelined_rca_adder;

    localparam int STAGES = 4;
`ifdef PRCA_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct packed {
        logic popped;
        logic pop_ok;
        logic acc;
        logic ovld;
        logic irdy;
        res_t obs;
        res_t exp;
    } tick_t;

    logic        CLK, RST, IN_VALID, C_IN, SUB, OUT_READY;
    logic [15:0] A, B;
    logic        IN_READY, OUT_VALID, C_OUT;
    logic [15:0] SUM;
    logic        ovf_w;

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t sb[$];

    pipelined_rca_adder #(.WIDTH(16), .SEG_W(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .C_IN      (C_IN),
        .SUB       (SUB),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .SUM       (SUM),
        .C_OUT     (C_OUT)
`ifdef PRCA_OVF_EN
        ,
        .OVF       (ovf_w)
`endif
    );

`ifndef PRCA_OVF_EN
    assign ovf_w = 1'b0;
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    // Reference: plain integer arithmetic on the operands.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        int   ua, ub, ur, sa, sbv, sr;
        res_t r;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        ur  = sub ? (ua - ub - int'(cin)) : (ua + ub + int'(cin));
        sr  = sub ? (sa - sbv - int'(cin)) : (sa + sbv + int'(cin));
        r.sum  = ur[15:0];
        r.cout = sub ? (ur >= 0) : (ur > 65535);
        r.ovf  = OVF_ON && ((sr > 32767) || (sr < -32768));
        return r;
    endfunction

    // One clock: sample handshakes just before the edge, update the scoreboard, cross the edge.
    task automatic tick(output tick_t r);
        #1;
        r = '0;
        r.ovld     = OUT_VALID;
        r.irdy     = IN_READY;
        r.popped   = (OUT_VALID === 1'b1) && OUT_READY;
        r.obs.sum  = SUM;
        r.obs.cout = C_OUT;
        r.obs.ovf  = ovf_w;
        if (r.popped && sb.size() > 0) begin
            r.exp    = sb.pop_front();
            r.pop_ok = 1'b1;
        end
        r.acc = IN_VALID && (IN_READY === 1'b1) && !RST;
        if (r.acc) sb.push_back(model(A, B, C_IN, SUB));
        @(posedge CLK);
        #1;
    endtask

    task automatic run_pair(input logic [15:0] a0, input logic [15:0] b0, input logic c0, input logic s0,
                            input logic [15:0] a1, input logic [15:0] b1, input logic c1, input logic s1,
                            output tick_t r0, output tick_t r1, output int got);
        tick_t t;
        got = 0;
        r0 = '0;
        r1 = '0;
        OUT_READY = 1'b1;
        for (int c = 0; c < 24 && got < 2; c++) begin
            IN_VALID = (c < 2);
            A    = (c == 0) ? a0 : a1;
            B    = (c == 0) ? b0 : b1;
            C_IN = (c == 0) ? c0 : c1;
            SUB  = (c == 0) ? s0 : s1;
            tick(t);
            if (t.popped) begin
                if (got == 0) r0 = t; else r1 = t;
                got++;
            end
        end
        IN_VALID = 1'b0;
    endtask

    task automatic test_reset();
        tick_t t;
        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
        A = '0; B = '0; C_IN = 1'b0; SUB = 1'b0;
        tick(t);
        tick(t);
        RST = 1'b0;
        sb.delete();
        n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", OUT_VALID); end
        n_cmp++; if (SUM !== 16'h0000) begin n_bad++; $display("FAIL reset_sum got %h want 0000", SUM); end
        n_cmp++; if (C_OUT !== 1'b0) begin n_bad++; $display("FAIL reset_c_out got %b want 0", C_OUT); end
        n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", IN_READY); end
`ifdef PRCA_OVF_EN
        n_cmp++; if (ovf_w !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", ovf_w); end
`endif
    endtask

    task automatic test_add_wrap();
        tick_t t, got;
        int    lat = 0;
        got = '0;
        A = 16'hFFFF; B = 16'h0001; C_IN = 1'b0; SUB = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b1;
        tick(t);
        IN_VALID = 1'b0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            tick(t);
            if (t.popped) begin lat = c; got = t; end
        end
        n_cmp++; if (lat != STAGES) begin n_bad++; $display("FAIL add_wrap_latency got %0d want %0d", lat, STAGES); end
        n_cmp++; if (got.obs.sum !== 16'h0000) begin n_bad++; $display("FAIL add_wrap_sum got %h want 0000", got.obs.sum); end
        n_cmp++; if (got.obs.cout !== 1'b1) begin n_bad++; $display("FAIL add_wrap_cout got %b want 1", got.obs.cout); end
`ifdef PRCA_OVF_EN
        n_cmp++; if (got.obs.ovf !== 1'b0) begin n_bad++; $display("FAIL add_wrap_ovf got %b want 0", got.obs.ovf); end
`endif
    endtask

    task automatic test_sub();
        tick_t r0, r1;
        int    got;
        run_pair(16'h1234, 16'h0235, 1'b0, 1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1, r0, r1, got);
        n_cmp++; if (got != 2) begin n_bad++; $display("FAIL sub_count got %0d want 2", got); end
        n_cmp++; if ({r0.obs.sum, r0.obs.cout} !== {16'h0FFF, 1'b1})
            begin n_bad++; $display("FAIL sub_no_borrow got %h/%b want 0fff/1", r0.obs.sum, r0.obs.cout); end
        n_cmp++; if ({r1.obs.sum, r1.obs.cout} !== {16'hFFFF, 1'b0})
            begin n_bad++; $display("FAIL sub_borrow got %h/%b want ffff/0", r1.obs.sum, r1.obs.cout); end
    endtask

    task automatic test_ovf();
        tick_t r0, r1;
        int    got;
        run_pair(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h0001, 1'b0, 1'b1, r0, r1, got);
        n_cmp++; if (got != 2) begin n_bad++; $display("FAIL ovf_count got %0d want 2", got); end
        n_cmp++; if ({r0.obs.sum, r0.obs.cout} !== {16'h8000, 1'b0})
            begin n_bad++; $display("FAIL ovf_add got %h/%b want 8000/0", r0.obs.sum, r0.obs.cout); end
        n_cmp++; if ({r1.obs.sum, r1.obs.cout} !== {16'h7FFF, 1'b1})
            begin n_bad++; $display("FAIL ovf_sub got %h/%b want 7fff/1", r1.obs.sum, r1.obs.cout); end
`ifdef PRCA_OVF_EN
        n_cmp++; if ({r0.obs.ovf, r1.obs.ovf} !== 2'b11)
            begin n_bad++; $display("FAIL ovf_flag got %b%b want 11", r0.obs.ovf, r1.obs.ovf); end
`endif
    endtask

    task automatic test_back_to_back();
        tick_t t;
        int    i = 0, k = 0, prev_t = 0;
        logic  gap = 1'b0;
        OUT_READY = 1'b1;
        for (int c = 0; c < 40 && k < 8; c++) begin
            if (i < 8) begin
                A = 16'(i); B = 16'h00FF; C_IN = 1'b0; SUB = i[0]; IN_VALID = 1'b1;
            end else begin
                IN_VALID = 1'b0;
            end
            tick(t);
            if (t.acc) i++;
            if (t.popped) begin
                n_cmp++;
                if (!t.pop_ok || t.obs !== t.exp) begin
                    n_bad++;
                    $display("FAIL b2b_result[%0d] got %h/%b/%b want %h/%b/%b", k,
                             t.obs.sum, t.obs.cout, t.obs.ovf, t.exp.sum, t.exp.cout, t.exp.ovf);
                end
                if (k > 0 && c != prev_t + 1) gap = 1'b1;
                prev_t = c;
                k++;
            end
        end
        IN_VALID = 1'b0;
        n_cmp++; if (k != 8 || gap) begin n_bad++; $display("FAIL b2b_stream got %0d results gap=%b want 8 gap=0", k, gap); end
    endtask

    task automatic test_backpressure();
        tick_t       t;
        int          i = 0, k = 0;
        logic        held_v = 1'b0;
        logic [15:0] held = '0;
        for (int c = 0; c < 80 && k < 10; c++) begin
            OUT_READY = !(c >= 6 && c < 11);
            if (i < 10) begin
                A = 16'h1000 + 16'(i * 'h0111); B = 16'(i * 'h0F0F);
                C_IN = i[2]; SUB = i[0] ^ i[1]; IN_VALID = 1'b1;
            end else begin
                IN_VALID = 1'b0;
            end
            tick(t);
            if (t.acc) i++;
            if (!OUT_READY && t.ovld) begin
                n_cmp++; if (t.irdy !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready cycle %0d got %b want 0", c, t.irdy); end
                if (held_v) begin
                    n_cmp++; if (t.obs.sum !== held) begin n_bad++; $display("FAIL bp_hold cycle %0d got %h want %h", c, t.obs.sum, held); end
                end
                held = t.obs.sum;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (t.popped) begin
                n_cmp++;
                if (!t.pop_ok || t.obs !== t.exp) begin
                    n_bad++;
                    $display("FAIL bp_result[%0d] got %h/%b want %h/%b", k, t.obs.sum, t.obs.cout, t.exp.sum, t.exp.cout);
                end
                k++;
            end
        end
        OUT_READY = 1'b1; IN_VALID = 1'b0;
        n_cmp++; if (k != 10 || sb.size() != 0) begin n_bad++; $display("FAIL bp_count got %0d left %0d want 10 left 0", k, sb.size()); end
    endtask

    task automatic test_random();
        tick_t t;
        int    i = 0, k = 0;
        for (int c = 0; c < 600 && (i < 40 || sb.size() > 0); c++) begin
            OUT_READY = (i >= 40) || ($urandom_range(9, 0) < 7);
            if (i < 40 && ($urandom_range(3, 0) != 0)) begin
                A = 16'($urandom); B = 16'($urandom); C_IN = 1'($urandom); SUB = 1'($urandom); IN_VALID = 1'b1;
            end else begin
                IN_VALID = 1'b0;
            end
            tick(t);
            if (t.acc) i++;
            if (t.popped) begin
                n_cmp++;
                if (!t.pop_ok || t.obs !== t.exp) begin
                    n_bad++;
                    $display("FAIL rand_result[%0d] got %h/%b/%b want %h/%b/%b", k,
                             t.obs.sum, t.obs.cout, t.obs.ovf, t.exp.sum, t.exp.cout, t.exp.ovf);
                end
                k++;
            end
        end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        n_cmp++; if (k != 40 || sb.size() != 0) begin n_bad++; $display("FAIL rand_count got %0d left %0d want 40 left 0", k, sb.size()); end
    endtask

    task automatic test_flush();
        tick_t t;
        logic  seen = 1'b0;
        OUT_READY = 1'b1;
        for (int c = 0; c < 3; c++) begin
            A = 16'h0100 * 16'(c + 1); B = 16'h0011; C_IN = 1'b1; SUB = 1'b0; IN_VALID = 1'b1;
            tick(t);
        end
        IN_VALID = 1'b0;
        RST = 1'b1;
        tick(t);
        RST = 1'b0;
        sb.delete();
        n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid got %b want 0", OUT_VALID); end
        n_cmp++; if (SUM !== 16'h0000) begin n_bad++; $display("FAIL flush_sum got %h want 0000", SUM); end
        for (int c = 0; c < 10; c++) begin
            tick(t);
            if (t.ovld !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen) begin n_bad++; $display("FAIL flush_stale got valid output want none"); end
    endtask

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
        A = '0; B = '0; C_IN = 1'b0; SUB = 1'b0;
        @(posedge CLK);
        #1;
        test_reset();
        test_add_wrap();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_ovf();
        test_random();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
